iopage_bus_master: RTL
======================

Name: iopage_bus_master

Overview:
- Initiator side of the I/O-page register bus.
- Takes single-word or single-byte requests from the CPU data path and sequences them onto the shared iopage bus: address, rd/wr strobe, byte-op flag.
- Collects the OR of all device `decode` lines and the OR of device read data.
- Returns read data with an ack, or a nonexistent-device bus error after a timeout.
- Sits between the CPU memory-access logic and all iopage register blocks (PSW, MMU, console, etc.).

Parameters:
- ADDR_W, 13, iopage byte address width.
- DATA_W, 16, data width.
- TIMEOUT, 4, cycles to wait for any device `decode` before signalling bus error (range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- req_wr  input  1  1=write, 0=read.
- req_byte  input  1  byte operation.
- req_addr  input  13  iopage byte address.
- req_data  input  16  write data; byte writes use bits [7:0].
- ack  output  1  one-cycle completion pulse.
- rd_data  output  16  read result, valid with ack.
- bus_err  output  1  one-cycle error pulse, mutually exclusive with ack.
- busy  output  1  high in any state other than IDLE.
- iopage_addr  output  13  address to devices.
- iopage_data_out  output  16  write data to devices (lane-steered).
- iopage_rd  output  1  read strobe.
- iopage_wr  output  1  write strobe.
- iopage_byte_op  output  1  byte-op flag.
- iopage_decode  input  1  OR of all device decode outputs.
- iopage_data_in  input  16  OR of all device data outputs.

Behaviour:
- Reset (async, active-high) values: state=IDLE; all outputs 0; internal address, data and timeout registers cleared.
- IDLE:
  - busy=0.
  - On req=1: latch addr, wr, byte and data; clear the timeout counter; go to ADDR.
- ADDR:
  - Drive iopage_addr and iopage_byte_op from the latched values. Strobes stay low.
  - If iopage_decode=1: go to XFER.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to ERR.
  - Decode is checked before the counter, so decode in the final timeout cycle wins.
- XFER:
  - Assert exactly one strobe (iopage_rd or iopage_wr) for exactly one cycle; address stays stable.
  - Read: capture iopage_data_in at the end of the cycle.
  - Go to DONE.
- DONE:
  - ack=1 for one cycle; rd_data holds the result until the next ack; go to IDLE.
- ERR:
  - bus_err=1 for one cycle; rd_data unchanged; no strobe was issued; go to IDLE.
- Latency: req at cycle N with decode already present gives strobe at N+2 and ack at N+3. Each missing decode cycle adds one.
- Byte lanes, where A0 = latched addr bit 0:
  - Byte write: iopage_data_out = A0 ? {req_data[7:0], 8'h00} : {8'h00, req_data[7:0]}.
  - Byte read: rd_data = {8'h00, A0 ? data_in[15:8] : data_in[7:0]}. Sign extension is the CPU's job.
  - Word access: data passes straight through.
- iopage_addr and iopage_byte_op are held constant from ADDR through XFER. They read 0 in IDLE, DONE and ERR.
- req while busy is ignored. The requester must wait for ack or bus_err.
- Reset asserted mid-transaction aborts immediately with no ack and no bus_err.
- A device that drops decode during XFER is still completed normally. Decode is sampled in ADDR only.

Optional Feature:
- Macro: IOPAGE_ODD_WORD_TRAP_EN.
- Defined: a word request with req_addr[0]=1 goes IDLE -> ERR directly, giving bus_err on cycle N+1 with no bus activity.
- Undefined: A0 is ignored for word accesses. The full address is driven, and devices see the odd address as given.

Decomposition:
- Shared package iopage_pkg holds:
  - The state enum (IDLE, ADDR, XFER, DONE, ERR).
  - IOPAGE_ADDR_W=13 and IOPAGE_DATA_W=16.
  - The default timeout constant.
  - The iopage base address 13'o00000 and the PSW address 13'o17776, for benches.
- One natural sub-module, iopage_byte_lane: purely combinational steering for both write data and read data. It is shared with future DMA initiators.

Test Plan:
- Word read of 13'o17776, device drives decode and data_in=16'o000340 -> iopage_rd high for 1 cycle at N+2; ack at N+3; rd_data=16'o000340; bus_err never asserted.
- Word write 16'o000017 to 13'o17776 -> iopage_wr for exactly 1 cycle, iopage_data_out=16'o000017, iopage_byte_op=0; ack at N+3.
- Byte write 8'hA5 to 13'o17777 -> iopage_data_out=16'hA500, iopage_byte_op=1. Byte read at odd address with data_in=16'h12F0 -> rd_data=16'h0012.
- Read of unmapped 13'o00100, decode never asserted, TIMEOUT=4 -> no strobe; bus_err single pulse at N+5 (IDLE->ADDR at N+1, counter reaches 4 at N+4, ERR at N+5); ack stays 0.
- Decode delayed 3 cycles into ADDR -> ack delayed by 3 cycles with correct data. Reset asserted during XFER -> all outputs 0 immediately, and the next req completes normally.
- With IOPAGE_ODD_WORD_TRAP_EN defined, word read at 13'o17777 -> bus_err at N+1, no strobe. Undefined -> normal cycle with iopage_addr=13'o17777.

Source files
------------

// File: rtl/iopage_pkg.sv
// Shared definitions for the iopage register bus: widths, default timeout,
// well-known addresses and the initiator state encoding.
package iopage_pkg;

  localparam int unsigned IOPAGE_ADDR_W       = 13;
  localparam int unsigned IOPAGE_DATA_W       = 16;
  localparam int unsigned IOPAGE_TIMEOUT_DEF  = 4;
  localparam int unsigned IOPAGE_CNT_W        = 4;

  localparam logic [IOPAGE_ADDR_W-1:0] IOPAGE_BASE_ADDR = 13'o00000;
  localparam logic [IOPAGE_ADDR_W-1:0] IOPAGE_PSW_ADDR  = 13'o17776;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_XFER = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } iopage_state_e;

endpackage

// File: rtl/iopage_bus_master_byte_lane.sv
// Combinational byte-lane steering for iopage initiators: places byte write
// data on the lane selected by A0 and right-justifies byte read data.
module iopage_byte_lane
  import iopage_pkg::*;
#(
  parameter int unsigned DATA_W = IOPAGE_DATA_W
) (
  input  logic              i_a0,
  input  logic              i_byte,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic [DATA_W-1:0] o_wdata_c,
  output logic [DATA_W-1:0] o_rdata_c
);

  localparam int unsigned PAD_W = DATA_W - 8;

  // Word accesses pass straight through; sign extension is left to the CPU.
  always_comb begin
    o_wdata_c = i_wdata;
    o_rdata_c = i_bus_rdata;
    if (i_byte) begin
      o_wdata_c = i_a0 ? {i_wdata[7:0], PAD_W'(0)} : {PAD_W'(0), i_wdata[7:0]};
      o_rdata_c = {PAD_W'(0), (i_a0 ? i_bus_rdata[DATA_W-1 -: 8] : i_bus_rdata[7:0])};
    end
  end

endmodule

// File: rtl/iopage_bus_master.sv
// Initiator for the iopage register bus: sequences one CPU word/byte access,
// waits up to TIMEOUT cycles for a device decode, then acks or raises bus_err.
// Optional: define IOPAGE_ODD_WORD_TRAP_EN to trap odd-address word requests.
module iopage_bus_master
  import iopage_pkg::*;
#(
  parameter int unsigned ADDR_W  = IOPAGE_ADDR_W,
  parameter int unsigned DATA_W  = IOPAGE_DATA_W,
  parameter int unsigned TIMEOUT = IOPAGE_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_wr,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              bus_err,
  output logic              busy,
  output logic [ADDR_W-1:0] iopage_addr,
  output logic [DATA_W-1:0] iopage_data_out,
  output logic              iopage_rd,
  output logic              iopage_wr,
  output logic              iopage_byte_op,
  input  logic              iopage_decode,
  input  logic [DATA_W-1:0] iopage_data_in
);

  iopage_state_e           r_state, w_state_nxt;
  logic [IOPAGE_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  logic [ADDR_W-1:0] r_addr, w_addr_src;
  logic              r_wr, r_byte, w_byte_src, w_ld;
  logic [DATA_W-1:0] r_wdata, r_rd_data;
  logic [DATA_W-1:0] w_wdata_lane, w_rdata_lane;

  logic              r_ack, r_bus_err, r_busy, r_iop_rd, r_iop_wr, r_iop_byte;
  logic [ADDR_W-1:0] r_iop_addr;
  logic [DATA_W-1:0] r_iop_dout;

  logic              w_ack_nxt, w_err_nxt, w_busy_nxt, w_rd_nxt, w_wr_nxt, w_byte_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_dout_nxt;

  assign w_ld       = (r_state == ST_IDLE) && req;
  assign w_addr_src = w_ld ? req_addr : r_addr;
  assign w_byte_src = w_ld ? req_byte : r_byte;
  assign w_cnt_inc  = r_cnt + IOPAGE_CNT_W'(1);

  iopage_byte_lane #(
    .DATA_W (DATA_W)
  ) u_byte_lane (
    .i_a0        (r_addr[0]),
    .i_byte      (r_byte),
    .i_wdata     (r_wdata),
    .i_bus_rdata (iopage_data_in),
    .o_wdata_c   (w_wdata_lane),
    .o_rdata_c   (w_rdata_lane)
  );

  // State and timeout counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; decode is tested before the counter so a late decode still wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_cnt_nxt = '0;
`ifdef IOPAGE_ODD_WORD_TRAP_EN
          if (!req_byte && req_addr[0]) w_state_nxt = ST_ERR;
          else                          w_state_nxt = ST_ADDR;
`else
          w_state_nxt = ST_ADDR;
`endif
        end
      end
      ST_ADDR: begin
        if (iopage_decode) begin
          w_state_nxt = ST_XFER;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == IOPAGE_CNT_W'(TIMEOUT)) w_state_nxt = ST_ERR;
        end
      end
      ST_XFER: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_addr_nxt = '0;
    w_byte_nxt = 1'b0;
    w_rd_nxt   = 1'b0;
    w_wr_nxt   = 1'b0;
    w_dout_nxt = '0;
    w_ack_nxt  = 1'b0;
    w_err_nxt  = 1'b0;
    case (w_state_nxt)
      ST_ADDR: begin
        w_addr_nxt = w_addr_src;
        w_byte_nxt = w_byte_src;
      end
      ST_XFER: begin
        w_addr_nxt = r_addr;
        w_byte_nxt = r_byte;
        w_rd_nxt   = !r_wr;
        w_wr_nxt   = r_wr;
        if (r_wr) w_dout_nxt = w_wdata_lane;
      end
      ST_DONE: w_ack_nxt = 1'b1;
      ST_ERR:  w_err_nxt = 1'b1;
      default: ;
    endcase
  end

  // Request latch, read capture and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_byte     <= 1'b0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_ack      <= 1'b0;
      r_bus_err  <= 1'b0;
      r_busy     <= 1'b0;
      r_iop_rd   <= 1'b0;
      r_iop_wr   <= 1'b0;
      r_iop_byte <= 1'b0;
      r_iop_addr <= '0;
      r_iop_dout <= '0;
    end else begin
      if (w_ld) begin
        r_addr  <= req_addr;
        r_wr    <= req_wr;
        r_byte  <= req_byte;
        r_wdata <= req_data;
      end
      if ((r_state == ST_XFER) && !r_wr) r_rd_data <= w_rdata_lane;
      r_ack      <= w_ack_nxt;
      r_bus_err  <= w_err_nxt;
      r_busy     <= w_busy_nxt;
      r_iop_rd   <= w_rd_nxt;
      r_iop_wr   <= w_wr_nxt;
      r_iop_byte <= w_byte_nxt;
      r_iop_addr <= w_addr_nxt;
      r_iop_dout <= w_dout_nxt;
    end
  end

  assign ack             = r_ack;
  assign rd_data         = r_rd_data;
  assign bus_err         = r_bus_err;
  assign busy            = r_busy;
  assign iopage_addr     = r_iop_addr;
  assign iopage_data_out = r_iop_dout;
  assign iopage_rd       = r_iop_rd;
  assign iopage_wr       = r_iop_wr;
  assign iopage_byte_op  = r_iop_byte;

endmodule
